// File: rtl/ctrl_pkg.sv
// Shared types and constants for the OTTER multicycle control FSM: state encoding,
// RV32I opcodes and the datapath mux-select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        LOAD   = 4'd4,
        STORE  = 4'd5,
        BRANCH = 4'd6,
        JAL    = 4'd7,
        JALR   = 4'd8,
        LUI    = 4'd9,
        AUIPC  = 4'd10,
        HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        ADDR_PC  = 1'b0,
        ADDR_ALU = 1'b1
    } addr_src_t;

    typedef enum logic [1:0] {
        REG_PC  = 2'd0,
        REG_ALU = 2'd1,
        REG_MEM = 2'd2
    } reg_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } immed_src_t;

    typedef enum logic [1:0] {
        A_CURR_PC = 2'd0,
        A_OLD_PC  = 2'd1,
        A_RS1     = 2'd2,
        A_ZERO    = 2'd3
    } alu_src_a_t;

    typedef enum logic [1:0] {
        B_RS2   = 2'd0,
        B_IMMED = 2'd1,
        B_FOUR  = 2'd2
    } alu_src_b_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [2:0] F3_SHR   = 3'b101;
    localparam logic [1:0] SZ_WORD  = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode to execute state, func3/f7b5 to ALU op.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       f7b5,
    output state_t     next_exec,
    output logic [3:0] alu_op
);

    always_comb begin
        next_exec = HALT;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                next_exec = EXEC_R;
                alu_op    = {f7b5, func3};
            end
            OP_ITYPE: begin
                next_exec = EXEC_I;
                // inst[30] is immediate data except for the shift-right pair
                alu_op    = {(func3 == F3_SHR) & f7b5, func3};
            end
            OP_LOAD:   next_exec = LOAD;
            OP_STORE:  next_exec = STORE;
            OP_BRANCH: next_exec = BRANCH;
            OP_JAL:    next_exec = JAL;
            OP_JALR:   next_exec = JALR;
            OP_LUI:    next_exec = LUI;
            OP_AUIPC:  next_exec = AUIPC;
            default:   next_exec = HALT;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM for the OTTER datapath, including the memory handshake.
// CTRL_MEM_WAIT_EN defined: honour mem_ready wait states; undefined: single-cycle memory.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on ack
// DECODE | dispatch on opcode
// EXEC_R | register-register ALU op, write rd
// EXEC_I | register-immediate ALU op, write rd
// LOAD   | read at rs1+imm, write rd on ack
// STORE  | write at rs1+imm, hold until ack
// BRANCH | conditional PC load to old_pc+imm
// JAL    | PC = old_pc+imm, rd = pc
// JALR   | PC = rs1+imm, rd = pc
// LUI    | rd = imm
// AUIPC  | rd = old_pc+imm
// HALT   | stopped, leaves only through rst
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    output logic        pcUpdate,
    output logic        enBranch,
    output logic        irWrite,
    output logic        addrSrc,
    output logic [1:0]  regSrc,
    output logic        regWrite,
    output logic [2:0]  immedSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [3:0]  aluOp,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic        retire,
    output logic        halt
);

    state_t     state;
    state_t     exec_state;
    logic [3:0] dec_alu_op;
    logic       mem_ok;
    logic       rst_q;
    logic       unused_inst;

    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    ctrl_decode u_decode (
        .opcode    (inst[6:0]),
        .func3     (inst[14:12]),
        .f7b5      (inst[30]),
        .next_exec (exec_state),
        .alu_op    (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            // Bring-up mode: a fresh reset parks in HALT, a second pulse releases to FETCH
            if (!RESET_HALT)
                state <= FETCH;
            else if (!rst_q)
                state <= (state == HALT) ? FETCH : HALT;
        end else begin
            case (state)
                FETCH:       if (mem_ok) state <= DECODE;
                DECODE:      state <= exec_state;
                LOAD, STORE: if (mem_ok) state <= FETCH;
                HALT:        state <= HALT;
                default:     state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcUpdate = 1'b0;
        enBranch = 1'b0;
        irWrite  = 1'b0;
        addrSrc  = ADDR_PC;
        regSrc   = REG_PC;
        regWrite = 1'b0;
        immedSrc = IMM_I;
        aluSrcA  = A_CURR_PC;
        aluSrcB  = B_RS2;
        aluOp    = ALU_ADD;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_size = rst ? 2'b00 : SZ_WORD;
        retire   = 1'b0;
        halt     = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_rd   = 1'b1;
                    aluSrcB  = B_FOUR;
                    irWrite  = mem_ok;
                    pcUpdate = mem_ok;
                end
                EXEC_R: begin
                    aluSrcA  = A_RS1;
                    aluOp    = dec_alu_op;
                    regSrc   = REG_ALU;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                EXEC_I: begin
                    aluSrcA  = A_RS1;
                    aluSrcB  = B_IMMED;
                    aluOp    = dec_alu_op;
                    regSrc   = REG_ALU;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                LOAD: begin
                    aluSrcA  = A_RS1;
                    aluSrcB  = B_IMMED;
                    addrSrc  = ADDR_ALU;
                    mem_rd   = 1'b1;
                    mem_size = inst[13:12];
                    regSrc   = mem_ok ? REG_MEM : REG_PC;
                    regWrite = mem_ok;
                    retire   = mem_ok;
                end
                STORE: begin
                    aluSrcA  = A_RS1;
                    aluSrcB  = B_IMMED;
                    immedSrc = IMM_S;
                    addrSrc  = ADDR_ALU;
                    mem_wr   = 1'b1;
                    mem_size = inst[13:12];
                    retire   = mem_ok;
                end
                BRANCH: begin
                    aluSrcA  = A_OLD_PC;
                    aluSrcB  = B_IMMED;
                    immedSrc = IMM_B;
                    enBranch = 1'b1;
                    retire   = 1'b1;
                end
                JAL, JALR: begin
                    aluSrcA  = (state == JAL) ? A_OLD_PC : A_RS1;
                    aluSrcB  = B_IMMED;
                    immedSrc = (state == JAL) ? IMM_J : IMM_I;
                    pcUpdate = 1'b1;
                    regSrc   = REG_PC;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                LUI, AUIPC: begin
                    aluSrcA  = (state == LUI) ? A_ZERO : A_OLD_PC;
                    aluSrcB  = B_IMMED;
                    immedSrc = IMM_U;
                    regSrc   = REG_ALU;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                HALT:    halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a cycle-level instruction model pushes the expected
// control word each cycle; a negedge monitor pops and compares it against the DUT.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        mem_ready = 1'b0;
    logic        pcUpdate, enBranch, irWrite, addrSrc, regWrite;
    logic [1:0]  regSrc, aluSrcA, aluSrcB, mem_size;
    logic [2:0]  immedSrc;
    logic [3:0]  aluOp;
    logic        mem_rd, mem_wr, retire, halt;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .pcUpdate(pcUpdate), .enBranch(enBranch), .irWrite(irWrite), .addrSrc(addrSrc),
        .regSrc(regSrc), .regWrite(regWrite), .immedSrc(immedSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_size(mem_size), .retire(retire), .halt(halt)
    );

    logic [23:0] dut_vec;
    assign dut_vec = {pcUpdate, enBranch, irWrite, addrSrc, regSrc, regWrite, immedSrc,
                      aluSrcA, aluSrcB, aluOp, mem_rd, mem_wr, mem_size, retire, halt};

    logic [23:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int model_retires = 0;
    int dut_retires = 0;
    int phase = 0;   // 0 fetch, 1 decode, 2 execute, 3 halted

    function automatic logic [23:0] pack(
        input logic pc, input logic eb, input logic irw, input logic as,
        input logic [1:0] rs, input logic rw, input logic [2:0] imm,
        input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
        input logic rd, input logic wr, input logic [1:0] sz, input logic ret, input logic hl);
        return {pc, eb, irw, as, rs, rw, imm, a, b, op, rd, wr, sz, ret, hl};
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    // Reference table of the last-cycle control word for each instruction class
    function automatic logic [23:0] exec_word(input logic [31:0] i, input logic rdy);
        logic [2:0] f3;
        f3 = i[14:12];
        case (i[6:0])
            7'b0110011: return pack(0,0,0,0,2'd1,1,3'd0,2'd2,2'd0,{i[30],f3},0,0,2'd2,1,0);
            7'b0010011: return pack(0,0,0,0,2'd1,1,3'd0,2'd2,2'd1,
                                    {(f3 == 3'd5) & i[30], f3},0,0,2'd2,1,0);
            7'b0000011: return pack(0,0,0,1,rdy ? 2'd2 : 2'd0,rdy,3'd0,2'd2,2'd1,4'd0,
                                    1,0,i[13:12],rdy,0);
            7'b0100011: return pack(0,0,0,1,2'd0,0,3'd1,2'd2,2'd1,4'd0,0,1,i[13:12],rdy,0);
            7'b1100011: return pack(0,1,0,0,2'd0,0,3'd2,2'd1,2'd1,4'd0,0,0,2'd2,1,0);
            7'b1101111: return pack(1,0,0,0,2'd0,1,3'd4,2'd1,2'd1,4'd0,0,0,2'd2,1,0);
            7'b1100111: return pack(1,0,0,0,2'd0,1,3'd0,2'd2,2'd1,4'd0,0,0,2'd2,1,0);
            7'b0110111: return pack(0,0,0,0,2'd1,1,3'd3,2'd3,2'd1,4'd0,0,0,2'd2,1,0);
            default:    return pack(0,0,0,0,2'd1,1,3'd3,2'd1,2'd1,4'd0,0,0,2'd2,1,0);
        endcase
    endfunction

    // One clock of stimulus; the model predicts the control word for that cycle
    task automatic step(input logic r, input logic [31:0] i, input logic mr);
        logic rdy;
        logic [23:0] e;
        @(posedge clk);
        #1;
        rst = r;
        inst = i;
        mem_ready = mr;
`ifdef CTRL_MEM_WAIT_EN
        rdy = mr;
`else
        rdy = 1'b1;
`endif
        e = '0;
        if (r) begin
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    e = pack(rdy,0,rdy,0,2'd0,0,3'd0,2'd0,2'd2,4'd0,1,0,2'd2,0,0);
                    if (rdy) phase = 1;
                end
                1: begin
                    e = pack(0,0,0,0,2'd0,0,3'd0,2'd0,2'd0,4'd0,0,0,2'd2,0,0);
                    phase = known_op(i[6:0]) ? 2 : 3;
                end
                2: begin
                    e = exec_word(i, rdy);
                    if (e[1]) begin
                        phase = 0;
                        model_retires++;
                    end
                end
                default: e = pack(0,0,0,0,2'd0,0,3'd0,2'd0,2'd0,4'd0,0,0,2'd2,0,1);
            endcase
        end
        exp_q.push_back(e);
    endtask

    // Run one instruction to retirement (or HALT) with the given bus wait counts
    task automatic run_instr(input logic [31:0] i, input int wf, input int we);
        int start;
        int guard;
        logic mr;
        start = model_retires;
        guard = 0;
        do begin
            mr = 1'b1;
            if (phase == 0 && wf > 0) begin mr = 1'b0; wf--; end
            else if (phase == 2 && we > 0) begin mr = 1'b0; we--; end
            else if (phase == 1) mr = 1'($urandom);
            step(1'b0, i, mr);
            guard++;
        end while (model_retires == start && phase != 3 && guard < 40);
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (dut_vec !== e) begin
                bad++;
                $display("FAIL ctrl_word t=%0t inst=%h got=%h exp=%h", $time, inst, dut_vec, e);
            end
            if (retire === 1'b1) dut_retires++;
        end
    end

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0020A083;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] JALI = 32'h008000EF;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] SUB  = 32'h40208133;
    localparam logic [31:0] SRAI = 32'h4050D093;
    localparam logic [31:0] ORIN = 32'hFFF0E093;
    localparam logic [31:0] JALR_I = 32'h000080E7;
    localparam logic [31:0] LUI_I  = 32'h123450B7;
    localparam logic [31:0] AUIPC_I = 32'h00001097;
    localparam logic [31:0] SB   = 32'h00208023;

    logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [6:0] bad_ops[4] = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};

    initial begin
        logic [31:0] rnd;
        logic [6:0]  op;
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b1);

        run_instr(ADDI, 0, 0);
        run_instr(LW, 0, 2);
        run_instr(BEQ, 1, 0);
        run_instr(JALI, 0, 0);
        run_instr(SUB, 0, 0);
        run_instr(SRAI, 0, 0);
        run_instr(ORIN, 0, 0);
        run_instr(JALR_I, 2, 0);
        run_instr(LUI_I, 0, 0);
        run_instr(AUIPC_I, 0, 0);
        run_instr(SB, 0, 3);

        run_instr(32'hFFFFFFFF, 0, 0);
        repeat (20) step(1'b0, 32'hFFFFFFFF, 1'($urandom));
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        run_instr(ADDI, 1, 0);

        step(1'b0, SW, 1'b1);
        step(1'b0, SW, 1'b1);
        step(1'b0, SW, 1'b0);
        step(1'b1, SW, 1'b0);
        step(1'b0, SW, 1'b0);
        run_instr(SW, 0, 1);

        for (int n = 0; n < 150; n++) begin
            rnd = $urandom;
            op = ($urandom_range(0, 14) == 0) ? bad_ops[$urandom_range(0, 3)]
                                                : ops[$urandom_range(0, 8)];
            run_instr({rnd[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 2));
            if (phase == 3) begin
                repeat ($urandom_range(1, 5)) step(1'b0, {rnd[31:7], op}, 1'($urandom));
                step(1'b1, {rnd[31:7], op}, 1'($urandom));
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (dut_retires != model_retires) begin
            bad++;
            $display("FAIL retire_count got=%0d exp=%0d", dut_retires, model_retires);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
